// File: rtl/signed_bcd_converter.sv
// Signed two's-complement to sign + packed BCD magnitude converter.
// Iterative double-dabble, one input bit per clock, start/busy/done handshake.
module signed_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       din,
  output logic                  busy,
  output logic                  done,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(IN_W + 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t                state;
  logic [IN_W-1:0]       mag;
  logic [4*DIGITS-1:0]   scratch;
  logic [CW-1:0]         count;
  logic                  sign;

  logic [4*DIGITS-1:0]   next_scratch;
  logic [IN_W-1:0]       next_mag;
  logic [3:0]            digit;
  logic                  carry;

  // Add-3 on every digit >= 5, then shift {scratch, mag} left by one;
  // the carry chain moves each adjusted digit's MSB into the next digit.
  always_comb begin
    next_scratch = '0;
    digit        = '0;
    carry        = mag[IN_W-1];
    for (int d = 0; d < DIGITS; d++) begin
      digit = scratch[4*d +: 4];
      if (digit >= 4'd5)
        digit = digit + 4'd3;
      next_scratch[4*d +: 4] = {digit[2:0], carry};
      carry = digit[3];
    end
    next_mag = {mag[IN_W-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mag     <= '0;
      scratch <= '0;
      count   <= '0;
      sign    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign    <= din[IN_W-1];
            mag     <= din[IN_W-1] ? (~din + 1'b1) : din;
            scratch <= '0;
            count   <= CW'(IN_W);
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= next_scratch;
          mag     <= next_mag;
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            bcd   <= next_scratch;
            neg   <= sign;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
